cic_decim_tail: RTL and testbench



---
 rtl/cic_pkg.sv | 9 +
 rtl/cic_comb_stage.sv | 36 +++
 rtl/cic_decim_tail.sv | 89 ++++++++
 tb/tb_cic_decim_tail.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared helpers for the CIC decimator back end.
package cic_pkg;

   // Rates of 0 and 1 both pass every sample; otherwise keep once the phase reaches rate-1.
   function automatic logic phase_done(input logic [63:0] phase, input logic [63:0] rate);
      return (rate <= 64'd1) || (phase >= rate - 64'd1);
   endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: y[n] = x[n] - x[n-CIC_M], advanced only on input strobes.
module cic_comb_stage #(
   parameter int DW    = 32,
   parameter int CIC_M = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_str,
   input  logic signed [DW-1:0] in_data,
   output logic                 out_str,
   output logic signed [DW-1:0] out_data
);

   logic signed [DW-1:0] dly [CIC_M];

   // Subtraction wraps in DW bits; output data holds between strobes.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_str  <= 1'b0;
         out_data <= '0;
         for (int i = 0; i < CIC_M; i++) begin
            dly[i] <= '0;
         end
      end else begin
         out_str <= in_str;
         if (in_str) begin
            out_data <= in_data - dly[CIC_M-1];
            dly[0]   <= in_data;
            for (int i = 1; i < CIC_M; i++) begin
               dly[i] <= dly[i-1];
            end
         end
      end
   end

endmodule

// File: rtl/cic_decim_tail.sv
// CIC decimator back end: keep one of every R valid samples, then CIC_N comb stages.
module cic_decim_tail
   import cic_pkg::*;
#(
   parameter int DW            = 32,
   parameter int RATE_DW       = 32,
   parameter int CIC_R         = 10,
   parameter int CIC_N         = 7,
   parameter int CIC_M         = 1,
   parameter int VARIABLE_RATE = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic signed [DW-1:0] s_axis_in_tdata,
   input  logic                 s_axis_in_tvalid,
   input  logic [RATE_DW-1:0]   s_axis_rate_tdata,
   input  logic                 s_axis_rate_tvalid,
   output logic signed [DW-1:0] m_axis_out_tdata,
   output logic                 m_axis_out_tvalid
);

   logic [RATE_DW-1:0]   rate;
   logic [RATE_DW-1:0]   phase;
   logic                 ds_str;
   logic signed [DW-1:0] ds_data;

   generate
      if (VARIABLE_RATE != 0) begin : g_var_rate
         // A load takes effect from the next cycle, so a same-cycle sample sees the old rate.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               rate <= RATE_DW'(CIC_R);
            end else if (s_axis_rate_tvalid) begin
               rate <= s_axis_rate_tdata;
            end
         end
      end else begin : g_fixed_rate
         logic unused_rate;
         assign rate        = RATE_DW'(CIC_R);
         assign unused_rate = ^{s_axis_rate_tdata, s_axis_rate_tvalid};
      end
   endgenerate

   // Comparing with >= lets a rate decrease emit on the next valid sample instead of wrapping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         phase   <= '0;
         ds_str  <= 1'b0;
         ds_data <= '0;
      end else begin
         ds_str <= 1'b0;
         if (s_axis_in_tvalid) begin
            if (phase_done(64'(phase), 64'(rate))) begin
               ds_data <= s_axis_in_tdata;
               ds_str  <= 1'b1;
               phase   <= '0;
            end else begin
               phase <= phase + RATE_DW'(1);
            end
         end
      end
   end

   logic                 str  [CIC_N+1];
   logic signed [DW-1:0] data [CIC_N+1];

   assign str[0]  = ds_str;
   assign data[0] = ds_data;

   generate
      for (genvar k = 0; k < CIC_N; k++) begin : g_comb
         cic_comb_stage #(
            .DW    (DW),
            .CIC_M (CIC_M)
         ) u_comb (
            .clk      (clk),
            .reset_n  (reset_n),
            .in_str   (str[k]),
            .in_data  (data[k]),
            .out_str  (str[k+1]),
            .out_data (data[k+1])
         );
      end
   endgenerate

   assign m_axis_out_tvalid = str[CIC_N];
   assign m_axis_out_tdata  = data[CIC_N];

endmodule

// File: tb/tb_cic_decim_tail.sv
// Randomised bench for cic_decim_tail against a sample-level reference model.
module tb_cic_decim_tail;

   localparam int DW      = 16;
   localparam int RATE_DW = 8;
   localparam int CIC_R   = 4;
   localparam int CIC_N   = 3;
   localparam int CIC_M   = 2;

   logic                 clk = 1'b0;
   logic                 reset_n = 1'b0;
   logic signed [DW-1:0] s_axis_in_tdata = '0;
   logic                 s_axis_in_tvalid = 1'b0;
   logic [RATE_DW-1:0]   s_axis_rate_tdata = '0;
   logic                 s_axis_rate_tvalid = 1'b0;
   logic signed [DW-1:0] m_axis_out_tdata;
   logic                 m_axis_out_tvalid;

   cic_decim_tail #(
      .DW            (DW),
      .RATE_DW       (RATE_DW),
      .CIC_R         (CIC_R),
      .CIC_N         (CIC_N),
      .CIC_M         (CIC_M),
      .VARIABLE_RATE (1)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .s_axis_in_tdata    (s_axis_in_tdata),
      .s_axis_in_tvalid   (s_axis_in_tvalid),
      .s_axis_rate_tdata  (s_axis_rate_tdata),
      .s_axis_rate_tvalid (s_axis_rate_tvalid),
      .m_axis_out_tdata   (m_axis_out_tdata),
      .m_axis_out_tvalid  (m_axis_out_tvalid)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint               due;
      logic signed [DW-1:0] value;
   } exp_t;

   int                   checks = 0;
   int                   errors = 0;
   longint               edgeIdx = 0;
   int unsigned          modelRate;
   int unsigned          sinceKept;
   logic signed [DW-1:0] hist [CIC_N][$];
   exp_t                 expQ [$];
   logic signed [DW-1:0] heldOut;
   logic signed [DW-1:0] captured [$];
   bit                   capture = 1'b0;
   int                   impExp [7] = '{5, 0, -15, 0, 15, 0, -5};

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      modelRate = CIC_R;
      sinceKept = 0;
      for (int k = 0; k < CIC_N; k++) begin
         hist[k].delete();
      end
      expQ.delete();
      heldOut = '0;
   endtask

   // Each kept sample runs through CIC_N difference equations and appears CIC_N edges later.
   task automatic modelStep(input bit valid, input logic signed [DW-1:0] din,
                            input bit rv, input int unsigned rd);
      int unsigned          eff;
      logic signed [DW-1:0] x;
      logic signed [DW-1:0] prev;
      int                   n;
      if (valid) begin
         eff = (modelRate == 0) ? 1 : modelRate;
         if (sinceKept + 1 >= eff) begin
            sinceKept = 0;
            x = din;
            for (int k = 0; k < CIC_N; k++) begin
               hist[k].push_back(x);
               n = hist[k].size();
               prev = (n > CIC_M) ? hist[k][n-1-CIC_M] : '0;
               x = x - prev;
               if (hist[k].size() > CIC_M) void'(hist[k].pop_front());
            end
            expQ.push_back('{edgeIdx + CIC_N, x});
         end else begin
            sinceKept++;
         end
      end
      if (rv) modelRate = rd;
   endtask

   task automatic applyStimulus(input bit valid, input logic signed [DW-1:0] din,
                                input bit rv, input int unsigned rd);
      bit expValid;
      s_axis_in_tvalid   = valid;
      s_axis_in_tdata    = din;
      s_axis_rate_tvalid = rv;
      s_axis_rate_tdata  = RATE_DW'(rd);
      modelStep(valid, din, rv, rd);
      @(posedge clk);
      #1;
      expValid = 1'b0;
      if (expQ.size() > 0 && expQ[0].due == edgeIdx) begin
         expValid = 1'b1;
         heldOut  = expQ[0].value;
         void'(expQ.pop_front());
      end
      checkOutput("out_valid", longint'(m_axis_out_tvalid), longint'(expValid));
      checkOutput("out_data", longint'(m_axis_out_tdata), longint'(heldOut));
      if (capture && m_axis_out_tvalid) captured.push_back(m_axis_out_tdata);
      edgeIdx++;
   endtask

   task automatic applyReset();
      reset_n            = 1'b0;
      s_axis_in_tvalid   = 1'b1;
      s_axis_in_tdata    = DW'(77);
      s_axis_rate_tvalid = 1'b0;
      @(posedge clk);
      #1;
      modelReset();
      checkOutput("rst_valid", longint'(m_axis_out_tvalid), 0);
      checkOutput("rst_data", longint'(m_axis_out_tdata), 0);
      edgeIdx++;
      reset_n = 1'b1;
   endtask

   initial begin
      modelReset();
      applyReset();

      // Continuous ramp at the reset-time rate, then gapped valid.
      for (int k = 0; k < 24; k++) applyStimulus(1'b1, DW'(k), 1'b0, 0);
      for (int k = 0; k < 36; k++) applyStimulus(k % 3 == 0, DW'(k), 1'b0, 0);

      // Rate changes mid-stream, including same-cycle load with a sample.
      applyStimulus(1'b0, '0, 1'b1, 2);
      for (int k = 0; k < 12; k++) applyStimulus(1'b1, DW'(k), k == 7, 3);
      for (int k = 0; k < 12; k++) applyStimulus(1'b1, DW'(100 + k), k == 2, 1);
      for (int k = 0; k < 8; k++)  applyStimulus(1'b1, DW'(k * 3), k == 1, 0);

      // Impulse response with rate 1 from a clean pipeline.
      applyReset();
      applyStimulus(1'b0, '0, 1'b1, 1);
      capture = 1'b1;
      applyStimulus(1'b1, DW'(5), 1'b0, 0);
      for (int k = 0; k < 6; k++) applyStimulus(1'b1, '0, 1'b0, 0);
      for (int k = 0; k < CIC_N + 2; k++) applyStimulus(1'b0, '0, 1'b0, 0);
      capture = 1'b0;
      checkOutput("imp_count", longint'(captured.size()), 7);
      for (int i = 0; i < captured.size() && i < 7; i++) begin
         checkOutput($sformatf("imp%0d", i), longint'(captured[i]), longint'(impExp[i]));
      end

      // Wrap-around at the signed extremes.
      applyStimulus(1'b1, DW'(32767), 1'b0, 0);
      applyStimulus(1'b1, DW'(-32768), 1'b0, 0);
      applyStimulus(1'b1, DW'(32767), 1'b0, 0);
      applyStimulus(1'b1, DW'(-32768), 1'b0, 0);

      // Random traffic with occasional rate loads.
      for (int k = 0; k < 600; k++) begin
         applyStimulus($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 19) == 0,
                       $urandom_range(0, 6));
      end

      // Reset with samples in flight, then counting must restart at index 0 with rate CIC_R.
      applyStimulus(1'b0, '0, 1'b1, 1);
      for (int k = 0; k < 3; k++) applyStimulus(1'b1, DW'(40 + k), 1'b0, 0);
      applyReset();
      for (int k = 0; k < CIC_N + 3; k++) applyStimulus(1'b0, '0, 1'b0, 0);
      for (int k = 0; k < 16; k++) applyStimulus(1'b1, DW'(k), 1'b0, 0);
      for (int k = 0; k < CIC_N + 3; k++) applyStimulus(1'b0, '0, 1'b0, 0);

      checkOutput("drain", longint'(expQ.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
